// File: rtl/pc_stack_pkg.sv
// Shared constants and op decoding for the PC return-address stack.
package pc_stack_pkg;

  localparam int OVF_DISCARD = 0;
  localparam int OVF_REFUSE  = 1;
  localparam int FILL_COPY   = 0;
  localparam int FILL_ZERO   = 1;

  typedef enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} stk_op_t;

  function automatic stk_op_t decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Parametrised return-address stack: shift-register entries, saturating
// occupancy count, sticky overflow/underflow flags and a debug peek port.
module pc_return_stack
  import pc_stack_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 4,
  parameter int OVF_MODE = OVF_DISCARD,
  parameter int UNF_FILL = FILL_COPY,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             err_clr,
  input  logic [IDX_W-1:0] peek_idx,
  output logic [PC_W-1:0]  top_pc,
  output logic [PC_W-1:0]  peek_pc,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  logic [DEPTH-1:0][PC_W-1:0] stk, stk_nxt;
  logic [CNT_W-1:0]           cnt_nxt;
  logic                       ovf_nxt, unf_nxt;
  stk_op_t                    op;

  assign op     = decode_op(push, pop);
  assign top_pc = stk[0];
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));

  // Loop compare rather than direct index so out-of-range selects read 0.
  always_comb begin
    peek_pc = '0;
    for (int i = 0; i < DEPTH; i++)
      if (peek_idx == IDX_W'(i)) peek_pc = stk[i];
  end

  always_comb begin
    stk_nxt = stk;
    cnt_nxt = count;
    ovf_nxt = ovf & ~err_clr;
    unf_nxt = unf & ~err_clr;
    case (op)
      OP_PUSH: begin
        if (full && OVF_MODE == OVF_REFUSE) begin
          ovf_nxt = 1'b1;
        end else begin
          for (int i = DEPTH - 1; i > 0; i--) stk_nxt[i] = stk[i-1];
          stk_nxt[0] = push_pc;
          if (full) ovf_nxt = 1'b1;
          else      cnt_nxt = count + CNT_W'(1);
        end
      end
      // Empty pops still shift: the core's RET loads whatever falls out.
      OP_POP: begin
        for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stk[i+1];
        stk_nxt[DEPTH-1] = (UNF_FILL == FILL_ZERO) ? '0 : stk[DEPTH-1];
        if (empty) unf_nxt = 1'b1;
        else       cnt_nxt = count - CNT_W'(1);
      end
      OP_REPLACE: begin
        stk_nxt[0] = push_pc;
        if (empty) cnt_nxt = CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stk   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (ena) begin
      stk   <= stk_nxt;
      count <= cnt_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench: three stack configurations share one stimulus stream.
module tb_pc_return_stack;

  logic       clk, rst, ena, push, pop, err_clr;
  logic [9:0] push_pc;
  logic [1:0] peek_idx;

  // a: DEPTH4 discard/copy, b: DEPTH4 refuse/zero, c: DEPTH3 discard/copy
  logic [9:0] a_top, a_peek, b_top, b_peek, c_top, c_peek;
  logic [2:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic a_emp, a_full, a_ovf, a_unf, b_emp, b_full, b_ovf, b_unf;
  logic c_emp, c_full, c_ovf, c_unf;

  int total = 0;
  int bad   = 0;

  pc_return_stack #(.PC_W(10), .DEPTH(4), .OVF_MODE(0), .UNF_FILL(0)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .push(push), .pop(pop), .push_pc(push_pc),
    .err_clr(err_clr), .peek_idx(peek_idx), .top_pc(a_top), .peek_pc(a_peek),
    .count(a_cnt), .empty(a_emp), .full(a_full), .ovf(a_ovf), .unf(a_unf));

  pc_return_stack #(.PC_W(10), .DEPTH(4), .OVF_MODE(1), .UNF_FILL(1)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .push(push), .pop(pop), .push_pc(push_pc),
    .err_clr(err_clr), .peek_idx(peek_idx), .top_pc(b_top), .peek_pc(b_peek),
    .count(b_cnt), .empty(b_emp), .full(b_full), .ovf(b_ovf), .unf(b_unf));

  pc_return_stack #(.PC_W(10), .DEPTH(3), .OVF_MODE(0), .UNF_FILL(0)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .push(push), .pop(pop), .push_pc(push_pc),
    .err_clr(err_clr), .peek_idx(peek_idx), .top_pc(c_top), .peek_pc(c_peek),
    .count(c_cnt), .empty(c_emp), .full(c_full), .ovf(c_ovf), .unf(c_unf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic p, input logic q, input logic [9:0] pc);
    push = p; pop = q; push_pc = pc;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_pc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    push = 1'b1; pop = 1'b0; push_pc = 10'h3AB; ena = 1'b1;
    do_reset();
    push = 1'b0;
    total++; if (a_top !== 10'h000) begin bad++; $display("FAIL reset_top got=%h exp=%h", a_top, 10'h000); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
    total++; if ({a_emp, a_full, a_ovf, a_unf} !== 4'b1000) begin bad++; $display("FAIL reset_flags got=%b exp=1000", {a_emp, a_full, a_ovf, a_unf}); end
    total++; if ({b_emp, b_full, b_ovf, b_unf} !== 4'b1000) begin bad++; $display("FAIL reset_flags_b got=%b exp=1000", {b_emp, b_full, b_ovf, b_unf}); end
  endtask

  task automatic test_push3();
    do_reset();
    step(1, 0, 10'h101); step(1, 0, 10'h202); step(1, 0, 10'h303);
    peek_idx = 2'd2; #1;
    total++; if (a_top !== 10'h303) begin bad++; $display("FAIL push3_top got=%h exp=%h", a_top, 10'h303); end
    total++; if (a_cnt !== 3'd3) begin bad++; $display("FAIL push3_count got=%0d exp=3", a_cnt); end
    total++; if (a_peek !== 10'h101) begin bad++; $display("FAIL push3_peek2 got=%h exp=%h", a_peek, 10'h101); end
    total++; if ({a_ovf, a_unf, a_full, a_emp} !== 4'b0000) begin bad++; $display("FAIL push3_flags got=%b exp=0000", {a_ovf, a_unf, a_full, a_emp}); end
    total++; if ({c_full, c_cnt} !== {1'b1, 2'd3}) begin bad++; $display("FAIL push3_d3_full got=%b/%0d exp=1/3", c_full, c_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 0, 10'(i));
    peek_idx = 2'd3; #1;
    total++; if (a_top !== 10'd5) begin bad++; $display("FAIL ovf_discard_top got=%0d exp=5", a_top); end
    total++; if (a_peek !== 10'd2) begin bad++; $display("FAIL ovf_discard_peek3 got=%0d exp=2", a_peek); end
    total++; if ({a_cnt, a_full, a_ovf} !== {3'd4, 2'b11}) begin bad++; $display("FAIL ovf_discard_state got=%0d/%b/%b exp=4/1/1", a_cnt, a_full, a_ovf); end
    total++; if (b_top !== 10'd4) begin bad++; $display("FAIL ovf_refuse_top got=%0d exp=4", b_top); end
    total++; if (b_peek !== 10'd1) begin bad++; $display("FAIL ovf_refuse_peek3 got=%0d exp=1", b_peek); end
    total++; if ({b_cnt, b_ovf} !== {3'd4, 1'b1}) begin bad++; $display("FAIL ovf_refuse_state got=%0d/%b exp=4/1", b_cnt, b_ovf); end
    total++; if (c_peek !== 10'd0) begin bad++; $display("FAIL peek_out_of_range got=%0d exp=0", c_peek); end
    peek_idx = 2'd2; #1;
    total++; if (c_peek !== 10'd3) begin bad++; $display("FAIL d3_peek2 got=%0d exp=3", c_peek); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1, 0, 10'h0A1); step(1, 0, 10'h0B2);
    step(0, 1, 10'h000);
    total++; if ({a_top, a_cnt} !== {10'h0A1, 3'd1}) begin bad++; $display("FAIL pop1 got=%h/%0d exp=0a1/1", a_top, a_cnt); end
    step(0, 1, 10'h000);
    total++; if ({a_emp, a_unf} !== 2'b10) begin bad++; $display("FAIL pop2_empty got=%b exp=10", {a_emp, a_unf}); end
    step(0, 1, 10'h000);
    total++; if ({a_unf, a_cnt} !== {1'b1, 3'd0}) begin bad++; $display("FAIL pop3_unf got=%b/%0d exp=1/0", a_unf, a_cnt); end
    total++; if ({b_unf, b_cnt, b_top} !== {1'b1, 3'd0, 10'h000}) begin bad++; $display("FAIL pop3_unf_b got=%b/%0d/%h exp=1/0/000", b_unf, b_cnt, b_top); end
    // Full stack then one pop: bottom copy vs zero fill.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 10'(i));
    step(0, 1, 10'h000);
    peek_idx = 2'd3; #1;
    total++; if (a_peek !== 10'd1) begin bad++; $display("FAIL fill_copy got=%0d exp=1", a_peek); end
    total++; if (b_peek !== 10'd0) begin bad++; $display("FAIL fill_zero got=%0d exp=0", b_peek); end
    total++; if (a_top !== 10'd3) begin bad++; $display("FAIL pop_full_top got=%0d exp=3", a_top); end
    // Popping an empty stack shifts: put a value at bottom then drain.
    step(0, 1, 10'h000); step(0, 1, 10'h000); step(0, 1, 10'h000);
    total++; if ({a_top, a_cnt, a_unf} !== {10'd1, 3'd0, 1'b0}) begin bad++; $display("FAIL drain_copy got=%h/%0d/%b exp=001/0/0", a_top, a_cnt, a_unf); end
    step(0, 1, 10'h000);
    total++; if ({a_top, a_unf} !== {10'd1, 1'b1}) begin bad++; $display("FAIL empty_pop_copy got=%h/%b exp=001/1", a_top, a_unf); end
  endtask

  task automatic test_replace();
    do_reset();
    step(1, 0, 10'h0AA);
    step(1, 1, 10'h155);
    peek_idx = 2'd1; #1;
    total++; if ({a_top, a_cnt} !== {10'h155, 3'd1}) begin bad++; $display("FAIL replace got=%h/%0d exp=155/1", a_top, a_cnt); end
    total++; if (a_peek !== 10'h000) begin bad++; $display("FAIL replace_peek1 got=%h exp=000", a_peek); end
    do_reset();
    step(1, 1, 10'h3FF);
    total++; if ({a_top, a_cnt, a_unf, a_ovf} !== {10'h3FF, 3'd1, 2'b00}) begin bad++; $display("FAIL replace_empty got=%h/%0d/%b%b exp=3ff/1/00", a_top, a_cnt, a_unf, a_ovf); end
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 0, 10'(i));
    step(1, 1, 10'h2C3);
    total++; if ({a_top, a_cnt, a_ovf} !== {10'h2C3, 3'd4, 1'b0}) begin bad++; $display("FAIL replace_full got=%h/%0d/%b exp=2c3/4/0", a_top, a_cnt, a_ovf); end
  endtask

  task automatic test_err_clr();
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 0, 10'(i));
    err_clr = 1'b1;
    step(1, 0, 10'd6);
    total++; if ({a_ovf, b_ovf} !== 2'b11) begin bad++; $display("FAIL clr_vs_err got=%b exp=11", {a_ovf, b_ovf}); end
    err_clr = 1'b1;
    step(0, 0, 10'd0);
    total++; if ({a_ovf, b_ovf} !== 2'b00) begin bad++; $display("FAIL clr_alone got=%b exp=00", {a_ovf, b_ovf}); end
    total++; if (a_top !== 10'd6) begin bad++; $display("FAIL clr_top got=%0d exp=6", a_top); end
  endtask

  task automatic test_ena_and_midreset();
    do_reset();
    step(1, 0, 10'h011); step(1, 0, 10'h022);
    ena = 1'b0; err_clr = 1'b1;
    step(1, 1, 10'h3EE);
    step(0, 1, 10'h000);
    ena = 1'b1;
    total++; if ({a_top, a_cnt} !== {10'h022, 3'd2}) begin bad++; $display("FAIL ena_hold got=%h/%0d exp=022/2", a_top, a_cnt); end
    total++; if ({a_unf, a_ovf} !== 2'b00) begin bad++; $display("FAIL ena_hold_flags got=%b exp=00", {a_unf, a_ovf}); end
    for (int i = 0; i < 4; i++) step(1, 0, 10'h100 + 10'(i));
    total++; if ({a_ovf, a_cnt} !== {1'b1, 3'd4}) begin bad++; $display("FAIL burst_pre got=%b/%0d exp=1/4", a_ovf, a_cnt); end
    rst = 1'b1; ena = 1'b0;
    step(1, 0, 10'h1FF);
    rst = 1'b0; ena = 1'b1;
    total++; if ({a_top, a_cnt, a_ovf, a_unf} !== {10'h000, 3'd0, 2'b00}) begin bad++; $display("FAIL midreset got=%h/%0d/%b%b exp=000/0/00", a_top, a_cnt, a_ovf, a_unf); end
    total++; if ({b_top, b_cnt, b_ovf} !== {10'h000, 3'd0, 1'b0}) begin bad++; $display("FAIL midreset_b got=%h/%0d/%b exp=000/0/0", b_top, b_cnt, b_ovf); end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    push_pc = '0; peek_idx = '0;
    test_reset();
    test_push3();
    test_overflow();
    test_underflow();
    test_replace();
    test_err_clr();
    test_ena_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
